lcd_digit_renderer: RTL
=======================

# lcd_digit_renderer

Framebuffer writer directly upstream of the serial LCD driver. Renders the 20-bit value on `number_on_digitron` as five 8×16 hex glyphs into the 128×64 page-organised display RAM that the LCD driver reads through its `address`/`q` port. Each render rewrites the whole 1024-byte frame, one byte per clock, and is triggered when the value changes or on request.

## Interface
- `X0`, default 44: first glyph column. Requires X0+40 ≤ 128.
- `PAGE0`, default 3: upper glyph page; the glyph occupies PAGE0 and PAGE0+1. Requires PAGE0 ≤ 6.
- `INVERT`, default 0: when 1, every written byte is bitwise inverted.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `number_on_digitron`  in  20  value to display; nibble [19:16] is the leftmost digit.
- `refresh_req`  in  1  one-cycle pulse that forces a re-render.
- `ram_we`  out  1  write strobe to the framebuffer RAM write port.
- `ram_addr`  out  13  write address, = 128·page + col.
- `ram_wdata`  out  8  write byte; bit0 is the top pixel row of the page.
- `busy`  out  1  high while a render is in progress.
- `frame_done`  out  1  one-cycle pulse after the last write of a frame.

## Operation
- States: IDLE, SCAN.
- `pending` flag:
  - Set by reset.
  - Set by `refresh_req`.
  - Set whenever `number_on_digitron` ≠ `shown` (the latched copy).
- IDLE, with `pending`=1:
  - Latch `shown` ← `number_on_digitron`.
  - Clear `pending`; page=0, col=0.
  - Go to SCAN.
- SCAN, every cycle:
  - Assert `ram_we`.
  - Drive `ram_addr` = {3'b0, page[2:0], col[6:0]} and `ram_wdata` = pixel byte.
  - Increment col; when col wraps 127→0, increment page.
  - After the write of page 7 / col 127 (address 1023): go to IDLE and pulse `frame_done` in the following cycle.
- Pixel byte:
  - Glyph region: page ∈ {PAGE0, PAGE0+1} and X0 ≤ col < X0+40.
  - Inside the glyph region:
    - k = (col−X0)>>3.
    - c = (col−X0)&7.
    - half = page−PAGE0.
    - nibble = `shown`[19−4k : 16−4k].
    - byte = font(nibble, c, half).
  - Outside the glyph region: 8'h00.
  - XOR the result with 8'hFF when INVERT=1.
- Value changes during SCAN are not applied to the frame in progress. The comparison against `shown` sets `pending`, and a new frame starts right after the current one.
- `refresh_req` during SCAN sets `pending` (one extra frame).
- Arithmetic: col is 7 bits and page is 3 bits, wrapping naturally. `ram_addr`[12:10] is always 0.

## Timing
- All outputs are registered.
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_wdata`=0 (not inverted), `busy`=0, `frame_done`=0, state=IDLE, `shown`=0, `pending`=1.
- Trigger to first write: `pending` sampled high in IDLE at edge N, so `ram_we`=1 with address 0 from edge N+1.
- A frame is exactly 1024 consecutive `ram_we` cycles with no gaps and strictly ascending addresses 0..1023.
- `busy` is high exactly during those 1024 cycles.
- `frame_done` is high for the one cycle after the last write. A back-to-back frame starts one cycle after `frame_done`.
- Reset asserted mid-frame: all outputs clear immediately (asynchronously). After release, a full frame re-renders from address 0.
- Simultaneous events: a value change and `refresh_req` in the same cycle produce one frame only.

## Structure
- Shared package `lcd_pkg`:
  - FB_COLS=128, FB_PAGES=8, FB_BYTES=1024, ADDR_W=13.
  - GLYPH_W=8, NUM_DIGITS=5.
  - Render state enum {IDLE, SCAN}.
- Sub-module `lcd_font_rom`: purely combinational hex font, 16 glyphs × 2 halves × 8 columns.
  - Inputs: nibble[3:0], col[2:0], half.
  - Output: byte[7:0].

## Test plan
- Reset release with number 0x00000 → 1024 writes at addresses 0..1023. Byte at addr 128·3+44 = font(0,0,0), byte at addr 0 = 0x00, and `frame_done` one cycle after the addr-1023 write.
- Idle, then number → 0x12345 → a new frame starts two cycles later. Addr 128·4+52 = font(2,0,1) and addr 128·3+83 = font(5,7,0).
- Number changes 0x11111→0x22222 at write 500 of a frame → that frame completes showing 1s, and a second frame immediately follows showing 2s.
- Idle, unchanged value, `refresh_req` pulse → exactly one frame. Two pulses during SCAN → exactly one extra frame.
- `rst_n` low at write 300 → outputs 0 the same cycle. After release, the frame restarts at address 0.
- INVERT=1, number 0x00000 → addr 0 written 0xFF, and glyph bytes = ~font.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, render-state type and segment decoder for the LCD digit renderer.
package lcd_pkg;

    localparam int FB_COLS    = 128;
    localparam int FB_PAGES   = 8;
    localparam int FB_BYTES   = 1024;
    localparam int ADDR_W     = 13;
    localparam int GLYPH_W    = 8;
    localparam int NUM_DIGITS = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } render_state_e;

    // Hex digit to seven-segment pattern, bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] segs;
        case (nibble)
            4'h0: segs = 7'h7E;
            4'h1: segs = 7'h30;
            4'h2: segs = 7'h6D;
            4'h3: segs = 7'h79;
            4'h4: segs = 7'h33;
            4'h5: segs = 7'h5B;
            4'h6: segs = 7'h5F;
            4'h7: segs = 7'h70;
            4'h8: segs = 7'h7F;
            4'h9: segs = 7'h7B;
            4'hA: segs = 7'h77;
            4'hB: segs = 7'h1F;
            4'hC: segs = 7'h4E;
            4'hD: segs = 7'h3D;
            4'hE: segs = 7'h4F;
            default: segs = 7'h47;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/lcd_font_rom.sv
// Combinational 8x16 hex font. Glyphs are drawn as single-pixel seven-segment
// figures inside columns 1..6 / rows 1..14, leaving a blank border so adjacent
// digits stay visually separated. half=0 covers rows 0..7, half=1 rows 8..15;
// bit j of the output byte is row (8*half + j).
module lcd_font_rom
    import lcd_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic [2:0] i_col,
    input  logic       i_half,
    output logic [7:0] o_byte
);

    logic [6:0] w_segs;
    logic       w_horiz;
    logic       w_left;
    logic       w_right;

    assign w_segs  = seg_decode(i_nibble);
    assign w_horiz = (i_col >= 3'd1) && (i_col <= 3'd6);
    assign w_left  = (i_col == 3'd1);
    assign w_right = (i_col == 3'd6);

    // Assemble the column byte from whichever segments cross this column/half.
    always_comb begin
        o_byte = 8'h00;
        if (!i_half) begin
            if (w_horiz && w_segs[6]) o_byte |= 8'h02;   // a: row 1
            if (w_left  && w_segs[1]) o_byte |= 8'hFE;   // f: rows 1..7
            if (w_right && w_segs[5]) o_byte |= 8'hFE;   // b: rows 1..7
        end else begin
            if (w_horiz && w_segs[0]) o_byte |= 8'h01;   // g: row 8
            if (w_horiz && w_segs[3]) o_byte |= 8'h40;   // d: row 14
            if (w_left  && w_segs[1]) o_byte |= 8'h01;   // f: row 8
            if (w_left  && w_segs[2]) o_byte |= 8'h7F;   // e: rows 8..14
            if (w_right && w_segs[5]) o_byte |= 8'h01;   // b: row 8
            if (w_right && w_segs[4]) o_byte |= 8'h7F;   // c: rows 8..14
        end
    end

endmodule

// File: rtl/lcd_digit_renderer.sv
// Rewrites the whole 128x64 page-organised framebuffer, one byte per clock,
// showing number_on_digitron as five hex glyphs. A frame is triggered by reset,
// by refresh_req, or by the displayed value differing from the latched copy.
module lcd_digit_renderer
    import lcd_pkg::*;
#(
    parameter int X0     = 44,
    parameter int PAGE0  = 3,
    parameter int INVERT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [19:0]       number_on_digitron,
    input  logic              refresh_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [6:0] X0_C     = 7'(X0);
    localparam logic [7:0] X_END    = 8'(X0 + GLYPH_W * NUM_DIGITS);
    localparam logic [2:0] PG_LO    = 3'(PAGE0);
    localparam logic [2:0] PG_HI    = 3'(PAGE0 + 1);
    localparam logic [7:0] INV_MASK = (INVERT != 0) ? 8'hFF : 8'h00;
    localparam logic [9:0] LAST_LOC = 10'(FB_BYTES - 1);

    render_state_e r_state, w_state_nxt;
    logic [2:0]    r_page, w_page_nxt;
    logic [6:0]    r_col, w_col_nxt;
    logic [19:0]   r_shown, w_shown_nxt;
    logic          r_pending, w_pending_nxt;
    logic          r_we, w_we_nxt;
    logic [7:0]    r_wdata, w_wdata_nxt;
    logic          r_busy;
    logic          r_done, w_done_nxt;

    // Location being output now, and the location whose byte is prepared for the next cycle.
    logic [9:0]    w_loc_cur, w_loc_inc, w_loc;
    logic [19:0]   w_src;
    logic [2:0]    w_pg;
    logic [6:0]    w_cl;
    logic [5:0]    w_rel;
    logic          w_in_glyph;
    logic          w_half;
    logic [3:0]    w_nibble;
    logic [7:0]    w_glyph;
    logic [7:0]    w_pix;

    assign w_loc_cur = {r_page, r_col};
    assign w_loc_inc = w_loc_cur + 10'd1;
    // At frame start the first byte uses address 0 and the value being latched this edge.
    assign w_loc     = (r_state == IDLE) ? 10'd0 : w_loc_inc;
    assign w_src     = (r_state == IDLE) ? number_on_digitron : r_shown;
    assign w_pg      = w_loc[9:7];
    assign w_cl      = w_loc[6:0];
    assign w_rel     = 6'(w_cl - X0_C);
    assign w_half    = (w_pg == PG_HI);
    assign w_in_glyph = ((w_pg == PG_LO) || (w_pg == PG_HI))
                      && (w_cl >= X0_C) && ({1'b0, w_cl} < X_END);

    // Select the digit nibble for the glyph slot; slot 0 is the leftmost (MS) nibble.
    always_comb begin
        w_nibble = 4'h0;
        case (w_rel[5:3])
            3'd0:    w_nibble = w_src[19:16];
            3'd1:    w_nibble = w_src[15:12];
            3'd2:    w_nibble = w_src[11:8];
            3'd3:    w_nibble = w_src[7:4];
            3'd4:    w_nibble = w_src[3:0];
            default: w_nibble = 4'h0;
        endcase
    end

    lcd_font_rom u_font (
        .i_nibble (w_nibble),
        .i_col    (w_rel[2:0]),
        .i_half   (w_half),
        .o_byte   (w_glyph)
    );

    assign w_pix = (w_in_glyph ? w_glyph : 8'h00) ^ INV_MASK;

    // Next-state and next-output logic for the IDLE/SCAN render FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_page_nxt    = r_page;
        w_col_nxt     = r_col;
        w_shown_nxt   = r_shown;
        w_pending_nxt = r_pending | refresh_req | (number_on_digitron != r_shown);
        w_we_nxt      = 1'b0;
        w_wdata_nxt   = 8'h00;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    // Latching the value consumes any mismatch; only a coincident refresh survives.
                    w_state_nxt   = SCAN;
                    w_shown_nxt   = number_on_digitron;
                    w_pending_nxt = refresh_req;
                    w_page_nxt    = 3'd0;
                    w_col_nxt     = 7'd0;
                    w_we_nxt      = 1'b1;
                    w_wdata_nxt   = w_pix;
                end
            end
            SCAN: begin
                if (w_loc_cur == LAST_LOC) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_page_nxt  = 3'd0;
                    w_col_nxt   = 7'd0;
                end else begin
                    {w_page_nxt, w_col_nxt} = w_loc_inc;
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = w_pix;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, latched value, pending flag and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_page    <= 3'd0;
            r_col     <= 7'd0;
            r_shown   <= 20'h00000;
            r_pending <= 1'b1;
            r_we      <= 1'b0;
            r_wdata   <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_page    <= w_page_nxt;
            r_col     <= w_col_nxt;
            r_shown   <= w_shown_nxt;
            r_pending <= w_pending_nxt;
            r_we      <= w_we_nxt;
            r_wdata   <= w_wdata_nxt;
            r_busy    <= w_we_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign ram_we     = r_we;
    assign ram_addr   = ADDR_W'({r_page, r_col});
    assign ram_wdata  = r_wdata;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule
